chacha_keystream_xor: RTL and testbench
=======================================

CHACHA_KEYSTREAM_XOR -- requirements
Module: chacha_keystream_xor

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port start, input, 1 bit: one-cycle pulse that loads key, nonce and init_counter and begins a message.
REQ-004 SHALL have port key, input, 256 bits: key; word i = key[32i+31:32i].
REQ-005 SHALL have port nonce, input, 96 bits: nonce; word j = nonce[32j+31:32j].
REQ-006 SHALL have port init_counter, input, 32 bits: first block counter value.
REQ-007 SHALL have port state_out, output, 4x4 array of 32-bit word_t [row][col]: input matrix to the block-function core.
REQ-008 SHALL have port block_req, output, 1 bit: one-cycle pulse that starts the core (its setRounds).
REQ-009 SHALL have port block_ready, input, 1 bit: level from the core; keystream valid while high.
REQ-010 SHALL have port block_in, input, 4x4 array of word_t: keystream block from the core.
REQ-011 SHALL have port din, input, 32 bits: plaintext word.
REQ-012 SHALL have port din_valid, input, 1 bit: din is valid.
REQ-013 SHALL have port din_last, input, 1 bit: din is the final word of the message.
REQ-014 SHALL have port din_ready, output, 1 bit: block accepts din.
REQ-015 SHALL have port dout, output, 32 bits: ciphertext word.
REQ-016 SHALL have port dout_valid, output, 1 bit: dout is valid.
REQ-017 SHALL have port dout_last, output, 1 bit: dout is the final word.
REQ-018 SHALL have port dout_ready, input, 1 bit: downstream accepts dout.
REQ-019 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-020 SHALL have port ctr_overflow, output, 1 bit: sticky flag for block-counter exhaustion.

Function
REQ-021 SHALL build state_out from registers: row0 = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574; row1 = key words 0-3; row2 = key words 4-7; row3 = ctr, nonce words 0-2.
REQ-022 SHALL implement the FSM IDLE, REQ, WAIT, STREAM, DRAIN.
REQ-023 SHALL, in IDLE on start, register key, nonce and init_counter, clear ctr_overflow, and go to REQ; start SHALL be ignored in every other state.
REQ-024 SHALL, in REQ, assert block_req for exactly one cycle and go to WAIT.
REQ-025 SHALL, in WAIT, ignore block_ready during the first cycle after REQ; from the second cycle on, block_ready=1 SHALL capture all 16 block_in words into the keystream buffer, set widx=0 and go to STREAM.
REQ-026 SHALL use keystream word widx = block_in[widx/4][widx%4].
REQ-027 SHALL drive din_ready = (state==STREAM) && (!dout_valid || dout_ready).
REQ-028 SHALL, on a din handshake, register dout = din XOR ks[widx], dout_last = din_last, dout_valid = 1 on the next edge (1-cycle latency), and increment widx.
REQ-029 SHALL hold dout, dout_last and dout_valid stable until dout_ready=1; a handshake with no new input SHALL clear dout_valid.
REQ-030 SHALL, on a handshake with din_last=1, go to DRAIN regardless of widx.
REQ-031 SHALL, in DRAIN, go to IDLE once dout_valid=0 or a dout handshake occurs.
REQ-032 SHALL, on a handshake with widx==15 and din_last=0 and ctr != 0xFFFFFFFF, increment ctr (mod 2^32 not reached) and go to REQ.
REQ-033 SHALL, on that same condition with ctr == 0xFFFFFFFF, set ctr_overflow, not issue block_req, and go to DRAIN.
REQ-034 SHALL keep din_ready=0 in REQ and WAIT; a pending dout SHALL still drain during those states.
REQ-035 SHALL apply simultaneous din and dout handshakes in the same cycle (full throughput, one word per cycle within a block).

Reset
REQ-036 SHALL, on rst_n=0, asynchronously enter IDLE and clear block_req, dout_valid, dout_last, din_ready, busy, ctr_overflow, widx, ctr, dout, key and nonce registers and the keystream buffer to 0.
REQ-037 SHALL, on reset mid-message, discard any buffered keystream and pending dout; the next start begins a new message.

Verification
REQ-038 RFC 8439 2.4.2 vector (key 00..1f, nonce 000000000000004a00000000, counter 1, 114-byte text) with a reference core -> dout matches the RFC ciphertext, dout_last on the final word, exactly 2 block_req pulses.
REQ-039 init_counter=0xFFFFFFFE, 40-word message -> block_req counter values FFFFFFFE and FFFFFFFF; after word 32 ctr_overflow=1, no third block_req, return to IDLE.
REQ-040 din_valid held high, dout_ready toggling 1/0 -> no word lost or duplicated; dout is stable while stalled.
REQ-041 start pulsed during STREAM -> ignored; key and ctr unchanged.
REQ-042 rst_n low for 1 cycle during WAIT -> all outputs 0 immediately; a subsequent start with a fresh key produces correct keystream from word 0.
REQ-043 1-word message with din_last=1 -> dout = din XOR block word [0][0] one cycle after acceptance, then IDLE, busy=0.

Source files
------------

// File: rtl/chacha_keystream_xor_if.sv
// Shared word/block types and the bus bundle for chacha_keystream_xor.
// slave = the keystream XOR block, master = its surroundings.
package chacha_pkg;
  typedef logic [31:0] word_t;
  typedef word_t [3:0][3:0] blk_t;
endpackage

interface chacha_keystream_xor_if;
  import chacha_pkg::*;

  logic          start;
  logic [255:0]  key;
  logic [95:0]   nonce;
  logic [31:0]   init_counter;

  blk_t          state_out;
  logic          block_req;
  logic          block_ready;
  blk_t          block_in;

  logic [31:0]   din;
  logic          din_valid;
  logic          din_last;
  logic          din_ready;

  logic [31:0]   dout;
  logic          dout_valid;
  logic          dout_last;
  logic          dout_ready;

  logic          busy;
  logic          ctr_overflow;

  modport slave (
    input  start,
    input  key,
    input  nonce,
    input  init_counter,
    output state_out,
    output block_req,
    input  block_ready,
    input  block_in,
    input  din,
    input  din_valid,
    input  din_last,
    output din_ready,
    output dout,
    output dout_valid,
    output dout_last,
    input  dout_ready,
    output busy,
    output ctr_overflow
  );

  modport master (
    output start,
    output key,
    output nonce,
    output init_counter,
    input  state_out,
    input  block_req,
    output block_ready,
    output block_in,
    output din,
    output din_valid,
    output din_last,
    input  din_ready,
    input  dout,
    input  dout_valid,
    input  dout_last,
    output dout_ready,
    input  busy,
    input  ctr_overflow
  );
endinterface

// File: rtl/chacha_keystream_xor.sv
// ChaCha20 stream front-end: feeds an external block core and
// XORs each 16-word keystream block onto a 32-bit word stream.
module chacha_keystream_xor
  import chacha_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  chacha_keystream_xor_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ    = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] STREAM = 3'd3;
  localparam logic [2:0] DRAIN  = 3'd4;

  logic [2:0]   state;
  logic [2:0]   state_d;

  logic [255:0] key_q;
  logic [95:0]  nonce_q;
  word_t        ctr;
  blk_t         ks;
  logic [3:0]   widx;
  logic         wait_arm;
  logic         ovf;

  word_t        dout_q;
  logic         dout_valid_q;
  logic         dout_last_q;

  logic         load;
  logic         take_blk;
  logic         din_ready;
  logic         din_hs;
  logic         dout_hs;
  logic         blk_last;
  logic         ctr_max;
  logic         roll;
  logic         next_blk;
  logic         ovf_hit;
  word_t        ks_word;
  blk_t         st;

  assign load     = (state == IDLE) && bus.start;
  assign take_blk = (state == WAIT) && wait_arm
                    && bus.block_ready;
  assign din_ready = (state == STREAM)
                     && (!dout_valid_q || bus.dout_ready);
  assign din_hs   = din_ready && bus.din_valid;
  assign dout_hs  = dout_valid_q && bus.dout_ready;
  assign blk_last = (widx == 4'd15);
  assign ctr_max  = &ctr;
  assign roll     = din_hs && !bus.din_last && blk_last;
  assign next_blk = roll && !ctr_max;
  assign ovf_hit  = roll && ctr_max;
  assign ks_word  = ks[widx[3:2]][widx[1:0]];

  // Core input matrix assembled from the registered message context.
  always_comb begin
    st       = '0;
    st[0][0] = 32'h61707865;
    st[0][1] = 32'h3320646e;
    st[0][2] = 32'h79622d32;
    st[0][3] = 32'h6b206574;
    st[1][0] = key_q[31:0];
    st[1][1] = key_q[63:32];
    st[1][2] = key_q[95:64];
    st[1][3] = key_q[127:96];
    st[2][0] = key_q[159:128];
    st[2][1] = key_q[191:160];
    st[2][2] = key_q[223:192];
    st[2][3] = key_q[255:224];
    st[3][0] = ctr;
    st[3][1] = nonce_q[31:0];
    st[3][2] = nonce_q[63:32];
    st[3][3] = nonce_q[95:64];
  end

  // Next-state decode for the message sequencer.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (bus.start) state_d = REQ;
      end
      REQ: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (take_blk) state_d = STREAM;
      end
      STREAM: begin
        unique case (1'b1)
          din_hs && bus.din_last: state_d = DRAIN;
          ovf_hit:                state_d = DRAIN;
          next_blk:               state_d = REQ;
          default:                state_d = state;
        endcase
      end
      DRAIN: begin
        if (!dout_valid_q || dout_hs) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state, block counter, word index and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ctr      <= '0;
      widx     <= '0;
      wait_arm <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_d;
      // low during the first WAIT cycle, so a stale ready is skipped
      wait_arm <= (state == WAIT);
      if (load) begin
        ctr <= bus.init_counter;
        ovf <= 1'b0;
      end
      if (next_blk) ctr <= ctr + 32'd1;
      if (ovf_hit) ovf <= 1'b1;
      if (take_blk) widx <= '0;
      else if (din_hs) widx <= widx + 4'd1;
    end
  end

  // Key and nonce are latched once per message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q   <= '0;
      nonce_q <= '0;
    end else if (load) begin
      key_q   <= bus.key;
      nonce_q <= bus.nonce;
    end
  end

  // Keystream buffer holds one core block while it is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks <= '0;
    end else if (take_blk) begin
      ks <= bus.block_in;
    end
  end

  // Output register: one-word skid with full-rate handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
    end else if (din_hs) begin
      dout_q       <= bus.din ^ ks_word;
      dout_last_q  <= bus.din_last;
      dout_valid_q <= 1'b1;
    end else if (dout_hs) begin
      dout_valid_q <= 1'b0;
    end
  end

  assign bus.state_out    = st;
  assign bus.block_req    = (state == REQ);
  assign bus.din_ready    = din_ready;
  assign bus.dout         = dout_q;
  assign bus.dout_valid   = dout_valid_q;
  assign bus.dout_last    = dout_last_q;
  assign bus.busy         = (state != IDLE);
  assign bus.ctr_overflow = ovf;

endmodule

// File: tb/tb_chacha_keystream_xor.sv
// Bench for chacha_keystream_xor: reference ChaCha20 core model,
// scoreboard of expected ciphertext words.
module tb_chacha_keystream_xor;
  import chacha_pkg::*;

  typedef logic [15:0][31:0] w16_t;
  typedef struct {
    logic [31:0] data;
    logic [31:0] mask;
    logic        last;
  } exp_t;

  localparam logic [127:0] SIGMA =
    {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chacha_keystream_xor_if bus();

  chacha_keystream_xor u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int fails = 0;

  exp_t        sb[$];
  logic [31:0] exp_ctr[$];
  logic [31:0] pt[64];
  logic [31:0] xp[64];
  logic [31:0] mk[64];
  logic [255:0] tb_key;
  logic [95:0]  tb_nonce;
  int nreq = 0;
  int rx = 0;
  int sent = 0;
  int rmode = 0;
  logic abort = 1'b0;

  task automatic chk(input string tag, input logic [511:0] got,
                     input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] v,
                                       input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic w16_t qr(input w16_t xi, input int a,
                              input int b, input int c, input int d);
    w16_t x = xi;
    x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
    x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
    x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
    x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
    return x;
  endfunction

  function automatic w16_t chacha(input w16_t s);
    w16_t x = s;
    for (int r = 0; r < 10; r++) begin
      x = qr(x, 0, 4, 8, 12);
      x = qr(x, 1, 5, 9, 13);
      x = qr(x, 2, 6, 10, 14);
      x = qr(x, 3, 7, 11, 15);
      x = qr(x, 0, 5, 10, 15);
      x = qr(x, 1, 6, 11, 12);
      x = qr(x, 2, 7, 8, 13);
      x = qr(x, 3, 4, 9, 14);
    end
    for (int i = 0; i < 16; i++) x[i] = x[i] + s[i];
    return x;
  endfunction

  function automatic w16_t init_st(input logic [255:0] k,
                                   input logic [95:0] n,
                                   input logic [31:0] c);
    w16_t s;
    s[0] = 32'h61707865;
    s[1] = 32'h3320646e;
    s[2] = 32'h79622d32;
    s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = c;
    s[13] = n[31:0];
    s[14] = n[63:32];
    s[15] = n[95:64];
    return s;
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // reference block core: stale ready lingers one cycle after req
  w16_t nxt_blk;
  logic [31:0] cexp;
  int lat_cnt = 0;
  logic lag = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.block_ready <= 1'b0;
      lag <= 1'b0;
      lat_cnt <= 0;
    end else if (bus.block_req) begin
      nreq++;
      chk("ctr_q", 512'(exp_ctr.size() != 0), 512'(1));
      if (exp_ctr.size() != 0) begin
        cexp = exp_ctr.pop_front();
        chk("state_out", 512'(bus.state_out),
            512'(init_st(tb_key, tb_nonce, cexp)));
      end
      nxt_blk = chacha(bus.state_out);
      lag <= 1'b1;
      lat_cnt <= 3 + int'($urandom_range(0, 3));
    end else if (lag) begin
      lag <= 1'b0;
      bus.block_ready <= 1'b0;
    end else if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1) begin
        bus.block_in <= nxt_blk;
        bus.block_ready <= 1'b1;
      end
    end
  end

  // downstream ready pattern
  initial begin
    bus.dout_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: bus.dout_ready = 1'b1;
        1: bus.dout_ready = !bus.dout_ready;
        default: bus.dout_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // output monitor: scoreboard pop and stall stability
  exp_t e;
  logic hold_v = 1'b0;
  logic [33:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v)
        chk("stall", 512'({bus.dout_valid, bus.dout_last, bus.dout}),
            512'(held));
      hold_v = bus.dout_valid && !bus.dout_ready;
      held = {bus.dout_valid, bus.dout_last, bus.dout};
      if (bus.dout_valid && bus.dout_ready) begin
        rx++;
        chk("sb_nonempty", 512'(sb.size() != 0), 512'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("dout", 512'(bus.dout & e.mask), 512'(e.data & e.mask));
          chk("dout_last", 512'(bus.dout_last), 512'(e.last));
        end
      end
    end
  end

  task automatic prep_model(input int n, input logic [255:0] k,
                            input logic [95:0] nn,
                            input logic [31:0] c0);
    w16_t b = '0;
    for (int i = 0; i < n; i++) begin
      if (i % 16 == 0) b = chacha(init_st(k, nn, c0 + 32'(i / 16)));
      pt[i] = $urandom();
      xp[i] = pt[i] ^ b[i % 16];
      mk[i] = '1;
    end
  endtask

  task automatic prep_rfc();
    string s;
    logic [911:0] ct;
    s = {"Ladies and Gentlemen of the class of '99: If I could ",
         "offer you only one tip for the future, sunscreen would be it."};
    ct = {128'h6e2e359a2568f98041ba0728dd0d6981,
          128'he97e7aec1d4360c20a27afccfd9fae0b,
          128'hf91b65c5524733ab8f593dabcd62b357,
          128'h1639d624e65152ab8f530c359f0861d8,
          128'h07ca0dbf500d6a6156a38e088a22b65e,
          128'h52bc514d16ccf806818ce91ab7793736,
          128'h5af90bbf74a35be6b40b8eedf2785e42,
          16'h874d};
    for (int i = 0; i < 29; i++) begin
      logic [31:0] p, x, m;
      p = '0; x = '0; m = '0;
      for (int b = 0; b < 4; b++) begin
        int j;
        j = 4 * i + b;
        if (j < 114) begin
          p[8*b +: 8] = s[j];
          x[8*b +: 8] = ct[911 - 8*j -: 8];
          m[8*b +: 8] = 8'hff;
        end
      end
      pt[i] = p; xp[i] = x; mk[i] = m;
    end
  endtask

  task automatic start_msg(input logic [255:0] k, input logic [95:0] n,
                           input logic [31:0] c);
    tb_key = k;
    tb_nonce = n;
    @(posedge clk); #1;
    bus.key = k;
    bus.nonce = n;
    bus.init_counter = c;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send_msg(input int n);
    int i = 0;
    int guard = 0;
    sent = 0;
    while (i < n && !abort && guard <= 400) begin
      @(posedge clk); #1;
      bus.din = pt[i];
      bus.din_last = (i == n - 1);
      bus.din_valid = 1'b1;
      @(negedge clk);
      if (bus.din_ready) begin
        sb.push_back('{xp[i], mk[i], (i == n - 1)});
        i++;
        sent++;
        guard = 0;
      end else begin
        guard++;
        if (!bus.busy) break;
      end
    end
    chk("din_tmo", 512'(guard > 400), 512'(0));
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    bus.din_last = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((bus.busy || sb.size() != 0) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 512'(k < 1000), 512'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int base_req, base_rx;
    logic [255:0] k;
    logic [95:0] n;
    bus.start = 1'b0;
    bus.key = '0;
    bus.nonce = '0;
    bus.init_counter = '0;
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.din_last = 1'b0;
    tb_key = '0;
    tb_nonce = '0;

    // reset state
    #12;
    chk("rst_out", 512'({bus.dout_valid, bus.dout_last, bus.busy,
        bus.din_ready, bus.block_req, bus.ctr_overflow, bus.dout}),
        512'(0));
    chk("rst_regs", 512'({bus.state_out[1], bus.state_out[2],
        bus.state_out[3]}), 512'(0));
    chk("rst_row0", 512'(bus.state_out[0]), 512'(SIGMA));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // RFC 8439 2.4.2 vector
    k = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    n = 96'h000000004a00000000000000;
    prep_rfc();
    exp_ctr.push_back(32'd1);
    exp_ctr.push_back(32'd2);
    rmode = 0;
    base_req = nreq;
    base_rx = rx;
    start_msg(k, n, 32'd1);
    send_msg(29);
    wait_idle("rfc_idle");
    chk("rfc_nreq", 512'(nreq - base_req), 512'(2));
    chk("rfc_words", 512'(rx - base_rx), 512'(29));

    // toggling dout_ready, start pulsed mid-stream
    k = rnd256();
    n = {$urandom(), $urandom(), $urandom()};
    prep_model(20, k, n, 32'd5);
    exp_ctr.push_back(32'd5);
    exp_ctr.push_back(32'd6);
    rmode = 1;
    base_req = nreq;
    base_rx = rx;
    start_msg(k, n, 32'd5);
    fork
      send_msg(20);
      begin
        for (int j = 0; j < 2000 && sent < 5; j++) @(negedge clk);
        @(posedge clk); #1;
        bus.key = ~k;
        bus.init_counter = 32'h0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
    join
    wait_idle("tog_idle");
    chk("tog_nreq", 512'(nreq - base_req), 512'(2));
    chk("tog_words", 512'(rx - base_rx), 512'(20));
    chk("ctr_hold", 512'(bus.state_out[3][0]), 512'(32'd6));

    // counter exhaustion
    k = rnd256();
    n = {$urandom(), $urandom(), $urandom()};
    prep_model(40, k, n, 32'hffff_fffe);
    exp_ctr.push_back(32'hffff_fffe);
    exp_ctr.push_back(32'hffff_ffff);
    rmode = 2;
    base_req = nreq;
    base_rx = rx;
    start_msg(k, n, 32'hffff_fffe);
    send_msg(40);
    wait_idle("ovf_idle");
    chk("ovf_flag", 512'(bus.ctr_overflow), 512'(1));
    chk("ovf_nreq", 512'(nreq - base_req), 512'(2));
    chk("ovf_words", 512'(rx - base_rx), 512'(32));
    chk("ovf_sent", 512'(sent), 512'(32));
    chk("ovf_ctr", 512'(bus.state_out[3][0]), 512'(32'hffff_ffff));

    // reset pulse while waiting on the second block
    k = rnd256();
    n = {$urandom(), $urandom(), $urandom()};
    prep_model(20, k, n, 32'd7);
    exp_ctr.push_back(32'd7);
    exp_ctr.push_back(32'd8);
    base_req = nreq;
    start_msg(k, n, 32'd7);
    chk("ovf_clr", 512'(bus.ctr_overflow), 512'(0));
    fork
      send_msg(20);
      begin
        for (int j = 0; j < 2000 && nreq - base_req < 2; j++)
          @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        abort = 1'b1;
        #1;
        chk("rst_mid", 512'({bus.dout_valid, bus.dout_last, bus.busy,
            bus.din_ready, bus.block_req, bus.ctr_overflow, bus.dout}),
            512'(0));
        chk("rst_mid_regs", 512'({bus.state_out[1], bus.state_out[2],
            bus.state_out[3]}), 512'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
    join
    sb.delete();
    exp_ctr.delete();
    abort = 1'b0;
    chk("rst_nreq", 512'(nreq - base_req), 512'(2));

    // fresh key after reset
    k = rnd256();
    n = {$urandom(), $urandom(), $urandom()};
    prep_model(18, k, n, 32'd0);
    exp_ctr.push_back(32'd0);
    exp_ctr.push_back(32'd1);
    rmode = 0;
    base_rx = rx;
    start_msg(k, n, 32'd0);
    send_msg(18);
    wait_idle("fresh_idle");
    chk("fresh_words", 512'(rx - base_rx), 512'(18));

    // single-word message
    k = rnd256();
    n = {$urandom(), $urandom(), $urandom()};
    prep_model(1, k, n, 32'd9);
    exp_ctr.push_back(32'd9);
    base_req = nreq;
    base_rx = rx;
    start_msg(k, n, 32'd9);
    send_msg(1);
    chk("one_lat", 512'({bus.dout_valid, bus.dout_last, bus.dout}),
        512'({1'b1, 1'b1, xp[0]}));
    wait_idle("one_idle");
    chk("one_busy", 512'(bus.busy), 512'(0));
    chk("one_nreq", 512'(nreq - base_req), 512'(1));
    chk("one_words", 512'(rx - base_rx), 512'(1));

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
